bw_sys_evt_sched: RTL and testbench
===================================

// Module: bw_sys_evt_sched
// PURPOSE
//  System-event scheduler in the jbus clock domain of the cmp bench system block.
//  Arbitrates round-robin among NREQ requesters (PLI/test hooks) for the shared
//  system pins: warm_rst_l, ext_int_l, temp_trig, clk_stretch.
//  Sequences exactly one event at a time: assert, hold, release, then a quiet gap.
// PARAMETERS
//  NREQ     4   number of requesters
//  LEN_W    8   width of per-request hold length
//  WRST_CYC 16  hold cycles for warm reset (req_len ignored)
//  GAP_CYC  4   quiet cycles after every event before next grant (>=1)
// PORTS
//  jbus_gclk   in  1           clock
//  j_rst_l     in  1           reset, asynchronous, active-high
//  req         in  NREQ        request, held high until gnt
//  req_evt     in  2*NREQ      per-requester event: 0 wrst,1 ext_int,2 temp_trig,3 clk_stretch
//  req_len     in  LEN_W*NREQ  per-requester hold cycles (0 treated as 1)
//  gnt         out NREQ        one-hot one-cycle grant pulse
//  done        out NREQ        one-hot one-cycle completion pulse
//  busy        out 1           FSM not IDLE
//  warm_rst_l  out 1           active-low warm reset
//  ext_int_l   out 1           active-low external interrupt
//  temp_trig   out 1           temperature trigger, active-high
//  clk_stretch out 1           clock stretch, active-high
// BEHAVIOUR
//  Reset (async, j_rst_l=1): state IDLE, rr ptr=0, gnt=0, done=0, busy=0,
//   warm_rst_l=1, ext_int_l=1, temp_trig=0, clk_stretch=0. Applies mid-event too.
//  FSM: IDLE -> ACT -> GAP -> IDLE.
//  IDLE: on edge with |req, pick first set req at/after ptr (wrap at NREQ-1->0);
//   gnt[w]<=1 for one cycle, latch evt=req_evt[w], cnt=(evt==0)?WRST_CYC:max(len,1);
//   ptr<=w+1 mod NREQ; go ACT. Selected pin asserts same edge as gnt (0 cycle lag).
//  ACT: pin held asserted; cnt decrements each cycle; at cnt==1 go GAP, pin released
//   on that edge. Active width = cnt cycles exactly.
//  GAP: done[w] pulses on first GAP cycle; all pins idle; after GAP_CYC cycles -> IDLE.
//   Earliest next gnt: edge ending last GAP cycle (event-to-event spacing = hold+GAP_CYC).
//  req sampled only in IDLE; req dropped before gnt = withdrawn, no gnt/done.
//  req_evt/req_len changes after gnt ignored. Only one pin ever active at a time.
//  busy = (state!=IDLE). gnt and done never both set for the same requester.
//  Counter width = max(LEN_W, clog2(WRST_CYC+1)); no wrap, len=0 -> 1 cycle.
// CONFIGURATION
//  BW_SYS_WRST_PREEMPT_EN defined: in ACT with latched evt!=0, any req[i] with
//   req_evt=0 preempts: current pin released, done[w] pulses, warm request granted
//   (rr order among warm requesters) on same edge, no GAP; ptr updated as normal.
//  Undefined: no preemption; warm reset waits for normal round-robin turn.
// TESTING
//  Single req[0], evt=1, len=5 -> gnt[0] pulse, ext_int_l low 5 cycles, done[0] next
//   cycle, busy low after 4 gap cycles.
//  req[0..3] all set, evt=2, len=2 -> grants order 0,1,2,3; temp_trig pulses 2 wide
//   spaced 6 cycles; ptr wraps, next grant to 0.
//  req[2] evt=0 len=3 -> warm_rst_l low exactly 16 cycles (len ignored).
//  len=0 evt=3 -> clk_stretch high 1 cycle; j_rst_l=1 mid-hold -> all pins idle
//   immediately, next grant starts from requester 0.
//  PREEMPT_EN: req[1] evt=3 len=50 active, req[3] evt=0 at cycle 10 -> clk_stretch drops,
//   done[1] and gnt[3] same cycle, warm_rst_l low 16; without macro warm waits 50+4.

Source files
------------

// File: rtl/bw_sys_evt_sched.sv
// Round-robin scheduler driving one shared system pin at a time: assert, hold, release, quiet gap.
// Optional macro BW_SYS_WRST_PREEMPT_EN lets a warm-reset request cut short any non-warm event.
module bw_sys_evt_sched #(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 8,
  parameter int WRST_CYC = 16,
  parameter int GAP_CYC  = 4
) (
  input  logic                    jbus_gclk,
  input  logic                    j_rst_l,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_evt,
  input  logic [LEN_W*NREQ-1:0]   req_len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    warm_rst_l,
  output logic                    ext_int_l,
  output logic                    temp_trig,
  output logic                    clk_stretch
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(WRST_CYC + 1);
  localparam int CW = (LEN_W > WW) ? LEN_W : WW;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ACT, GAP} state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   own_reg;
  logic [CW-1:0]   cnt_reg;
  logic [GW-1:0]   gap_reg;
  logic [3:0]      pin_reg;     // one bit per event code, active-high
  logic [NREQ-1:0] gnt_reg;
  logic [NREQ-1:0] done_reg;

  logic [PW:0]     rr_sel;
  logic            grant_en;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   ptr_next;
  logic [1:0]      grant_evt;
  logic [LEN_W-1:0] grant_len;
  logic [CW-1:0]   grant_cnt;

  // {hit, index} of the first set bit at or after p, wrapping
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] m, input logic [PW-1:0] p);
    logic [PW:0] r;
    int          j;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(p) + k) % NREQ;
      if (m[j]) r = {1'b1, PW'(j)};
    end
    return r;
  endfunction

`ifdef BW_SYS_WRST_PREEMPT_EN
  logic [NREQ-1:0] warm_req;
  logic [PW:0]     wm_sel;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_warm
      assign warm_req[gi] = req[gi] && (req_evt[2*gi +: 2] == 2'd0) && (own_reg != PW'(gi));
    end
  endgenerate

  assign wm_sel = rr_pick(warm_req, ptr_reg);
`endif

  always_comb begin
    rr_sel    = rr_pick(req, ptr_reg);
    grant_en  = 1'b0;
    grant_idx = rr_sel[PW-1:0];
    case (state_reg)
      IDLE: grant_en = rr_sel[PW];
      GAP:  grant_en = rr_sel[PW] && (gap_reg == '0);
      ACT: begin
`ifdef BW_SYS_WRST_PREEMPT_EN
        if (!pin_reg[0] && wm_sel[PW]) begin
          grant_en  = 1'b1;
          grant_idx = wm_sel[PW-1:0];
        end
`endif
      end
      default: ;
    endcase
    grant_evt = req_evt[2*grant_idx +: 2];
    grant_len = req_len[LEN_W*grant_idx +: LEN_W];
    if (grant_evt == 2'd0)
      grant_cnt = CW'(WRST_CYC);
    else if (grant_len == '0)
      grant_cnt = CW'(1);
    else
      grant_cnt = CW'(grant_len);
    ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge jbus_gclk or posedge j_rst_l) begin
    if (j_rst_l) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      own_reg   <= '0;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      pin_reg   <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      if (grant_en) begin
        // a grant while ACT is a preemption: close out the running event now
        if (state_reg == ACT) done_reg[own_reg] <= 1'b1;
        state_reg          <= ACT;
        gnt_reg[grant_idx] <= 1'b1;
        own_reg            <= grant_idx;
        cnt_reg            <= grant_cnt;
        ptr_reg            <= ptr_next;
        pin_reg            <= 4'b0001 << grant_evt;
      end else begin
        case (state_reg)
          ACT: begin
            if (cnt_reg <= CW'(1)) begin
              state_reg         <= GAP;
              pin_reg           <= '0;
              done_reg[own_reg] <= 1'b1;
              gap_reg           <= GW'(GAP_CYC - 1);
            end else begin
              cnt_reg <= cnt_reg - 1'b1;
            end
          end
          GAP: begin
            if (gap_reg == '0) state_reg <= IDLE;
            else               gap_reg   <= gap_reg - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign gnt         = gnt_reg;
  assign done        = done_reg;
  assign busy        = (state_reg != IDLE);
  assign warm_rst_l  = ~pin_reg[0];
  assign ext_int_l   = ~pin_reg[1];
  assign temp_trig   = pin_reg[2];
  assign clk_stretch = pin_reg[3];

endmodule

// File: tb/tb_bw_sys_evt_sched.sv
// Bench for bw_sys_evt_sched: directed scenarios plus random traffic against a timeline model.
module tb_bw_sys_evt_sched;
  localparam int NREQ = 4;
  localparam int WRST = 16;
  localparam int GAP  = 4;

  logic        jbus_gclk = 1'b0;
  logic        j_rst_l   = 1'b0;
  logic [3:0]  req       = '0;
  logic [7:0]  req_evt   = '0;
  logic [31:0] req_len   = '0;
  logic [3:0]  gnt, done;
  logic        busy, warm_rst_l, ext_int_l, temp_trig, clk_stretch;

  int total = 0;
  int bad   = 0;

  bw_sys_evt_sched #(.NREQ(4), .LEN_W(8), .WRST_CYC(WRST), .GAP_CYC(GAP)) dut (
    .jbus_gclk(jbus_gclk), .j_rst_l(j_rst_l), .req(req), .req_evt(req_evt), .req_len(req_len),
    .gnt(gnt), .done(done), .busy(busy), .warm_rst_l(warm_rst_l), .ext_int_l(ext_int_l),
    .temp_trig(temp_trig), .clk_stretch(clk_stretch));

  always #5 jbus_gclk = ~jbus_gclk;

  // Timeline model: each event is (start edge, hold); everything else follows from arithmetic.
  int   n = 0;
  int   m_start, m_hold, m_w, m_evt, m_ptr;
  bit   m_valid;
  logic [3:0] exp_gnt, exp_done, exp_pins;
  logic       exp_busy;

  function automatic int hold_of(int e, int l);
    return (e == 0) ? WRST : ((l == 0) ? 1 : l);
  endfunction

  function automatic int rr_first(logic [3:0] m, int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ptr = 0; m_start = 0; m_hold = 0; m_w = 0; m_evt = 0;
    exp_gnt = '0; exp_done = '0; exp_pins = '0; exp_busy = 1'b0;
  endtask

  task automatic model_step();
    int w;
    bit pre;
    n++;
    exp_gnt = '0; exp_done = '0;
    w = -1; pre = 0;
    if (j_rst_l) begin
      model_reset();
    end else begin
`ifdef BW_SYS_WRST_PREEMPT_EN
      if (m_valid && m_evt != 0 && n > m_start && n <= m_start + m_hold) begin
        logic [3:0] wm;
        for (int i = 0; i < NREQ; i++) wm[i] = req[i] && (req_evt[2*i +: 2] == 2'd0) && (i != m_w);
        w = rr_first(wm, m_ptr);
        if (w >= 0) begin pre = 1; exp_done[m_w] = 1'b1; end
      end
`endif
      if (!pre && m_valid && n == m_start + m_hold) exp_done[m_w] = 1'b1;
      if (!pre && (!m_valid || n >= m_start + m_hold + GAP)) w = rr_first(req, m_ptr);
      if (w >= 0) begin
        exp_gnt[w] = 1'b1;
        m_valid = 1; m_start = n; m_w = w;
        m_evt  = int'(req_evt[2*w +: 2]);
        m_hold = hold_of(m_evt, int'(req_len[8*w +: 8]));
        m_ptr  = (w + 1) % NREQ;
      end
      exp_pins = '0;
      if (m_valid && n >= m_start && n < m_start + m_hold) exp_pins[m_evt] = 1'b1;
      exp_busy = m_valid && (n < m_start + m_hold + GAP);
    end
  endtask

  task automatic tick();
    @(posedge jbus_gclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    j_rst_l = 1'b1; req = '0;
    model_reset();
    repeat (3) tick();
    j_rst_l = 1'b0;
  endtask

  function automatic logic [3:0] dut_pins();
    return {clk_stretch, temp_trig, ~ext_int_l, ~warm_rst_l};
  endfunction

  task automatic test_reset();
    #2 j_rst_l = 1'b1;
    model_reset();
    #1;
    total++; if (gnt !== 4'h0)      begin bad++; $display("FAIL reset_gnt got=%0h exp=0", gnt); end
    total++; if (done !== 4'h0)     begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (warm_rst_l !== 1'b1) begin bad++; $display("FAIL reset_warm got=%0b exp=1", warm_rst_l); end
    total++; if (ext_int_l !== 1'b1)  begin bad++; $display("FAIL reset_ext got=%0b exp=1", ext_int_l); end
    total++; if (temp_trig !== 1'b0)  begin bad++; $display("FAIL reset_temp got=%0b exp=0", temp_trig); end
    total++; if (clk_stretch !== 1'b0) begin bad++; $display("FAIL reset_clk got=%0b exp=0", clk_stretch); end
    do_reset();
  endtask

  task automatic test_single();
    int g, lo, first_lo, d, idle, other;
    do_reset();
    g = -1; lo = 0; first_lo = -1; d = -1; idle = -1; other = 0;
    req_evt[1:0] = 2'd1; req_len[7:0] = 8'd5; req[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gnt[0]) begin g = c; req[0] = 1'b0; end
      if (!ext_int_l) begin lo++; if (first_lo < 0) first_lo = c; end
      if (!warm_rst_l || temp_trig || clk_stretch) other++;
      if (done[0]) d = c;
      if (g >= 0 && !busy && idle < 0) idle = c;
    end
    total++; if (g != 0)          begin bad++; $display("FAIL single_gnt_time got=%0d exp=0", g); end
    total++; if (lo != 5)         begin bad++; $display("FAIL single_ext_width got=%0d exp=5", lo); end
    total++; if (first_lo != g)   begin bad++; $display("FAIL single_pin_lag got=%0d exp=%0d", first_lo, g); end
    total++; if (d != g + 5)      begin bad++; $display("FAIL single_done_time got=%0d exp=%0d", d, g + 5); end
    total++; if (idle != g + 5 + GAP) begin bad++; $display("FAIL single_busy_drop got=%0d exp=%0d", idle, g + 5 + GAP); end
    total++; if (other != 0)      begin bad++; $display("FAIL single_other_pins got=%0d exp=0", other); end
  endtask

  task automatic test_all_four();
    int k, rises, hi, gt[4], ord[4], rt[4];
    logic prev;
    logic [3:0] gv;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_evt[2*i +: 2] = 2'd2; req_len[8*i +: 8] = 8'd2; gt[i] = -1; ord[i] = -1; rt[i] = -1;
    end
    req = 4'hF; k = 0; rises = 0; hi = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (gnt[i]) begin
          if (k < 4) begin ord[k] = i; gt[k] = c; end
          k++; req[i] = 1'b0;
        end
      if (temp_trig && !prev) begin if (rises < 4) rt[rises] = c; rises++; end
      prev = temp_trig;
      if (temp_trig) hi++;
    end
    total++; if (k != 4)  begin bad++; $display("FAIL all4_grant_count got=%0d exp=4", k); end
    total++; if (hi != 8) begin bad++; $display("FAIL all4_temp_cycles got=%0d exp=8", hi); end
    for (int j = 0; j < 4; j++) begin
      total++; if (ord[j] != j)    begin bad++; $display("FAIL all4_order[%0d] got=%0d exp=%0d", j, ord[j], j); end
      total++; if (rt[j] != gt[j]) begin bad++; $display("FAIL all4_rise[%0d] got=%0d exp=%0d", j, rt[j], gt[j]); end
      if (j > 0) begin
        total++; if (gt[j] - gt[j-1] != 2 + GAP)
          begin bad++; $display("FAIL all4_spacing[%0d] got=%0d exp=%0d", j, gt[j] - gt[j-1], 2 + GAP); end
      end
    end
    req = 4'hF; gv = '0;
    for (int c = 0; c < 6 && gv == '0; c++) begin tick(); gv = gnt; end
    total++; if (gv !== 4'b0001) begin bad++; $display("FAIL all4_wrap_gnt got=%0h exp=1", gv); end
    req = '0;
  endtask

  task automatic test_wrst();
    int g, lo, d;
    do_reset();
    g = -1; lo = 0; d = -1;
    req_evt[5:4] = 2'd0; req_len[23:16] = 8'd3; req[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (gnt[2]) begin g = c; req[2] = 1'b0; end
      if (!warm_rst_l) lo++;
      if (done[2]) d = c;
    end
    total++; if (g != 0)       begin bad++; $display("FAIL wrst_gnt_time got=%0d exp=0", g); end
    total++; if (lo != WRST)   begin bad++; $display("FAIL wrst_width got=%0d exp=%0d", lo, WRST); end
    total++; if (d != g + WRST) begin bad++; $display("FAIL wrst_done_time got=%0d exp=%0d", d, g + WRST); end
  endtask

  task automatic test_len0_reset();
    int g, hi, d;
    logic [3:0] gv;
    do_reset();
    g = -1; hi = 0; d = -1;
    req_evt[7:6] = 2'd3; req_len[31:24] = 8'd0; req[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (gnt[3]) begin g = c; req[3] = 1'b0; end
      if (clk_stretch) hi++;
      if (done[3]) d = c;
    end
    total++; if (hi != 1)    begin bad++; $display("FAIL len0_width got=%0d exp=1", hi); end
    total++; if (d != g + 1) begin bad++; $display("FAIL len0_done_time got=%0d exp=%0d", d, g + 1); end
    req_evt[3:2] = 2'd3; req_len[15:8] = 8'd20; req[1] = 1'b1; g = -1;
    for (int c = 0; c < 10 && g < 0; c++) begin
      tick();
      if (gnt[1]) begin g = c; req[1] = 1'b0; end
    end
    repeat (5) tick();
    total++; if (clk_stretch !== 1'b1) begin bad++; $display("FAIL midhold_active got=%0b exp=1", clk_stretch); end
    #2 j_rst_l = 1'b1;
    model_reset();
    #1;
    total++; if (dut_pins() !== 4'h0) begin bad++; $display("FAIL midhold_pins got=%0h exp=0", dut_pins()); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL midhold_busy got=%0b exp=0", busy); end
    tick(); tick();
    j_rst_l = 1'b0;
    req_evt[1:0] = 2'd1; req_len[7:0] = 8'd1; req_evt[7:6] = 2'd1; req_len[31:24] = 8'd1;
    req = 4'b1001; gv = '0;
    for (int c = 0; c < 6 && gv == '0; c++) begin tick(); gv = gnt; end
    total++; if (gv !== 4'b0001) begin bad++; $display("FAIL postrst_ptr got=%0h exp=1", gv); end
    req = '0;
  endtask

  task automatic test_preempt();
    int g1, g3, d1, hi, lo, exp_g3, exp_hi;
    do_reset();
    g1 = -1; g3 = -1; d1 = -1; hi = 0; lo = 0;
    req_evt[3:2] = 2'd3; req_len[15:8] = 8'd50; req_evt[7:6] = 2'd0; req_len[31:24] = 8'd7;
    req[1] = 1'b1;
    for (int c = 0; c < 90; c++) begin
      tick();
      if (gnt[1]) begin g1 = c; req[1] = 1'b0; end
      if (gnt[3]) begin g3 = c; req[3] = 1'b0; end
      if (done[1]) d1 = c;
      if (clk_stretch) hi++;
      if (!warm_rst_l) lo++;
      if (g1 >= 0 && c == g1 + 9) req[3] = 1'b1;
    end
`ifdef BW_SYS_WRST_PREEMPT_EN
    exp_g3 = g1 + 10; exp_hi = 10;
    total++; if (d1 != g3) begin bad++; $display("FAIL preempt_done_vs_gnt got=%0d exp=%0d", d1, g3); end
`else
    exp_g3 = g1 + 50 + GAP; exp_hi = 50;
    total++; if (d1 != g1 + 50) begin bad++; $display("FAIL nopreempt_done got=%0d exp=%0d", d1, g1 + 50); end
`endif
    total++; if (g3 != exp_g3) begin bad++; $display("FAIL preempt_gnt3_time got=%0d exp=%0d", g3, exp_g3); end
    total++; if (hi != exp_hi) begin bad++; $display("FAIL preempt_clk_width got=%0d exp=%0d", hi, exp_hi); end
    total++; if (lo != WRST)   begin bad++; $display("FAIL preempt_warm_width got=%0d exp=%0d", lo, WRST); end
    req = '0;
  endtask

  task automatic test_random();
    int shown;
    shown = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      tick();
      total++; if (gnt !== exp_gnt) begin bad++;
        if (shown++ < 20) $display("FAIL rand_gnt cyc=%0d got=%0h exp=%0h", c, gnt, exp_gnt); end
      total++; if (done !== exp_done) begin bad++;
        if (shown++ < 20) $display("FAIL rand_done cyc=%0d got=%0h exp=%0h", c, done, exp_done); end
      total++; if (busy !== exp_busy) begin bad++;
        if (shown++ < 20) $display("FAIL rand_busy cyc=%0d got=%0b exp=%0b", c, busy, exp_busy); end
      total++; if (dut_pins() !== exp_pins) begin bad++;
        if (shown++ < 20) $display("FAIL rand_pins cyc=%0d got=%0h exp=%0h", c, dut_pins(), exp_pins); end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (exp_gnt[i]) req[i] = 1'b0;
          else if ($urandom_range(0, 59) == 0) req[i] = 1'b0;
        end else begin
          req_evt[2*i +: 2] = ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
          req_len[8*i +: 8] = 8'($urandom_range(0, 6));
          if ($urandom_range(0, 5) == 0) req[i] = 1'b1;
        end
      end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_wrst();
    test_len0_reset();
    test_preempt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
